data_output_register: RTL

//  Write-direction counterpart of the cpu6502 S/AC/X/Y registers: holds the byte to write to memory.

---
 rtl/cpu6502_pkg.sv | 14 +
 rtl/dor_latch.sv | 21 ++
 rtl/data_output_register.sv | 108 ++++++++++
 3 files changed

// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the cpu6502 datapath slice.
// Holds the write-sequencer state encoding and the R/W pin levels.
package cpu6502_pkg;

   typedef enum logic [1:0] {
      DOR_IDLE,
      DOR_WRITE,
      DOR_HOLD
   } dor_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dor_latch.sv
// Data output register storage: loads on the falling clock edge.
// This matches the S/AC/X/Y registers, so the bus value settles before the next rising edge.
module dor_latch #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_d,
   input  logic                  i_load,
   output logic [DATA_WIDTH-1:0] o_q
);

   always_ff @(negedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_q <= '0;
      end else if (i_load) begin
         o_q <= i_d;
      end
   end

endmodule

// File: rtl/data_output_register.sv
// Write-side data output register and bus sequencer: holds the byte to write
// and drives R/W plus the external data-bus output enable.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   DOR_IDLE  | bus released: rw=read, oe=0, data=0
//   DOR_WRITE | write cycle: rw=write, oe=1, DOR driven
//   DOR_HOLD  | rw back to read, DOR still driven for HOLD_CYCLES clocks
module data_output_register
   import cpu6502_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_load,
   input  logic                  i_write,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_data_oe,
   output logic                  o_rw,
   output logic                  o_busy
);

   if (HOLD_CYCLES < 0 || HOLD_CYCLES > 3) begin : g_bad_hold
      $error("data_output_register: HOLD_CYCLES must be in 0..3");
   end

   localparam logic [1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 2'(HOLD_CYCLES - 1) : 2'd0;
   localparam logic       HAS_HOLD  = (HOLD_CYCLES > 0);

   dor_state_t            state;
   logic [1:0]            hold_cnt;
   logic                  rw_q;
   logic                  oe_q;
   logic [DATA_WIDTH-1:0] dor;

   dor_latch #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_dor (
      .i_clk    (i_clk),
      .i_reset_n(i_reset_n),
      .i_d      (i_data),
      .i_load   (i_load),
      .o_q      (dor)
   );

   // Outputs are flopped alongside the state so nothing combinational reaches the pins from i_write.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state    <= DOR_IDLE;
         hold_cnt <= 2'd0;
         rw_q     <= RW_READ;
         oe_q     <= 1'b0;
      end else begin
         case (state)
            DOR_IDLE: begin
               if (i_write) begin
                  state <= DOR_WRITE;
                  rw_q  <= RW_WRITE;
                  oe_q  <= 1'b1;
               end
            end
            DOR_WRITE: begin
               if (!i_write) begin
                  rw_q <= RW_READ;
                  if (HAS_HOLD) begin
                     state    <= DOR_HOLD;
                     hold_cnt <= HOLD_INIT;
                     oe_q     <= 1'b1;
                  end else begin
                     state <= DOR_IDLE;
                     oe_q  <= 1'b0;
                  end
               end
            end
            DOR_HOLD: begin
               // A new write takes priority so back-to-back writes never drop the bus.
               if (i_write) begin
                  state <= DOR_WRITE;
                  rw_q  <= RW_WRITE;
                  oe_q  <= 1'b1;
               end else if (hold_cnt == 2'd0) begin
                  state <= DOR_IDLE;
                  rw_q  <= RW_READ;
                  oe_q  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 2'd1;
               end
            end
            default: begin
               state    <= DOR_IDLE;
               hold_cnt <= 2'd0;
               rw_q     <= RW_READ;
               oe_q     <= 1'b0;
            end
         endcase
      end
   end

   // DOR passes straight through while enabled so a falling-edge reload shows up within the same write cycle.
   assign o_data    = oe_q ? dor : '0;
   assign o_data_oe = oe_q;
   assign o_rw      = rw_q;
   assign o_busy    = oe_q;

endmodule
